// File: rtl/smp_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and CPU port indices.
package smp_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic CPU0 = 1'b0;
  localparam logic CPU1 = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// Per-CPU line port: miss/writeback request toward the arbiter and the completion coming back.
interface dmem_arb_if #(
  parameter int ADDR_W = 11,
  parameter int LINE_W = 64
);

  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rline;
  logic              rdy;

  // CPU side drives the request, the arbiter drives the completion.
  modport master (output addr, re, we, wline, input rline, rdy);
  modport slave  (input addr, re, we, wline, output rline, rdy);

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: a lone requester always wins, a tie goes to the
// port that did not win the previous tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// Arbiter steering two CPU line-miss/writeback ports onto one shared data memory.
// One transaction in flight, round-robin on ties, sticky error on timeout or conflicting op.
module dmem_arb
  import smp_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int LINE_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arb_if.slave         c0,
  dmem_arb_if.slave         c1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              err
);

  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;   // winner of the most recent tie
  logic              win_q, win_d;     // port owning the current transaction
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_d;
  logic              re_d, we_d, err_d;
  logic [LINE_W-1:0] wdata_d;
  logic [LINE_W-1:0] rline0_q, rline0_d, rline1_q, rline1_d;
  logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;

  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_re, sel_we;
  logic [LINE_W-1:0] sel_wline;
  logic              finish, upd_line;
  logic [LINE_W-1:0] line_val;

  assign req = {c1.re | c1.we, c0.re | c0.we};

  rr_arb2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    if (gnt[1]) begin
      sel_addr  = c1.addr;
      sel_re    = c1.re;
      sel_we    = c1.we;
      sel_wline = c1.wline;
    end else begin
      sel_addr  = c0.addr;
      sel_re    = c0.re;
      sel_we    = c0.we;
      sel_wline = c0.wline;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    tmo_d    = tmo_q;
    addr_d   = mem_addr;
    re_d     = mem_re;
    we_d     = mem_we;
    wdata_d  = mem_wdata;
    err_d    = err;
    rline0_d = rline0_q;
    rline1_d = rline1_q;
    rdy0_d   = 1'b0;
    rdy1_d   = 1'b0;
    finish   = 1'b0;
    upd_line = 1'b0;
    line_val = mem_rdata;

    case (state_q)
      ARB_IDLE: begin
        if (|gnt) begin
          win_d = gnt[1];
          if (&req) last_d = gnt[1];
          // A port raising both re and we is served as a write and flagged.
          addr_d  = sel_addr;
          we_d    = sel_we;
          re_d    = ~sel_we;
          wdata_d = sel_wline;
          if (sel_re & sel_we) err_d = 1'b1;
          tmo_d   = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_rdy) begin
          finish   = 1'b1;
          upd_line = ~mem_we;
          line_val = mem_rdata;
        end else if (tmo_q == TMO_MAX) begin
          finish   = 1'b1;
          upd_line = 1'b1;
          line_val = '0;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    if (finish) begin
      re_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rdy0_d  = (win_q == CPU0);
      rdy1_d  = (win_q == CPU1);
      state_d = ARB_DONE;
      if (upd_line) begin
        if (win_q == CPU1) rline1_d = line_val;
        else               rline0_d = line_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the returned-line holders are plain flops rather than a memory, so they take the reset too.
      state_q   <= ARB_IDLE;
      last_q    <= CPU1;
      win_q     <= CPU0;
      tmo_q     <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
      rline0_q  <= '0;
      rline1_q  <= '0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      tmo_q     <= tmo_d;
      mem_addr  <= addr_d;
      mem_re    <= re_d;
      mem_we    <= we_d;
      mem_wdata <= wdata_d;
      err       <= err_d;
      rline0_q  <= rline0_d;
      rline1_q  <= rline1_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
    end
  end

  assign c0.rline = rline0_q;
  assign c0.rdy   = rdy0_q;
  assign c1.rline = rline1_q;
  assign c1.rdy   = rdy1_q;

endmodule
